mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage placed directly downstream of the execute stage and upstream of writeback.
- Accepts one instruction per handshake from EX. For loads and stores whose request EX already issued, it waits for the data-SRAM response (data_ok). It aligns and extends load data, buffers responses when WB stalls, and forwards destination/readiness info to decode for hazard handling.
- Absorbs and discards responses that belong to instructions killed by an exception or ertn flush.

Parameters:
- ADDR_W, 32, width of PC and ALU result.
- DROP_W, 2, width of the discard counter (tracks up to 3 orphaned responses).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- es_to_ms_valid  in  1  EX has a valid instruction.
- ms_allowin  out  1  MS can accept from EX this cycle.
- es_pc  in  32  instruction PC.
- es_ld_op  in  5  one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu}; all zero means not a load.
- es_req_issued  in  1  EX's data-SRAM request was accepted for this instruction.
- es_dest  in  5  destination register.
- es_gr_we  in  1  register write enable.
- es_alu_result  in  32  ALU result / memory address.
- es_excp  in  1  instruction carries an exception.
- data_sram_data_ok  in  1  response valid, one-cycle pulse.
- data_sram_rdata  in  32  response data.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  valid to WB.
- ms_pc  out  32  registered PC.
- ms_dest  out  5  registered destination.
- ms_gr_we  out  1  registered write enable.
- ms_final_result  out  32  load data or ALU result.
- ms_excp  out  1  registered exception flag.
- ms_fwd_valid  out  1  MS holds a valid instruction that writes a GPR.
- ms_fwd_dest  out  5  destination for hazard checking.
- ms_fwd_ready  out  1  ms_final_result is usable for forwarding.
- flush  in  1  excp_flush or ertn_flush; kills the MS instruction.

Behaviour:
- Reset: ms_valid=0, pending=0, buf_valid=0, drop_cnt=0. All registered outputs are 0, so ms_to_ws_valid=0, ms_fwd_valid=0, and ms_allowin=1.
- Accept condition: es_to_ms_valid && ms_allowin && !flush. On accept, latch all es_* fields.
  - pending <= es_req_issued && !es_excp.
  - buf_valid <= 0.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_ready_go = !pending || buf_valid || (data_ok && drop_cnt==0).
- ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- Response routing:
  - If drop_cnt>0, a data_ok is consumed by the discard path: drop_cnt decrements and MS state is unchanged.
  - Otherwise, if ms_valid && pending && !buf_valid, data_ok is used by MS. When ws_allowin=0 the data is captured into buf and buf_valid is set.
  - data_ok arriving with no consumer is impossible by protocol; the bench asserts on it.
- Conceptual states: IDLE (!ms_valid), WAIT (pending, no data), READY (no request pending, or data present/buffered). Transitions:
  - IDLE -> WAIT or READY on accept.
  - WAIT -> READY on a routed data_ok.
  - READY -> next instruction on handshake with WB.
- Load data. Let off = ms_alu_result[1:0] and raw = buf_valid ? buf : data_sram_rdata.
  - byte = raw[8*off +: 8]; half = off[1] ? raw[31:16] : raw[15:0].
  - ld_b sign-extends byte; ld_bu zero-extends byte.
  - ld_h sign-extends half; ld_hu zero-extends half.
  - ld_w uses raw as-is.
  - Non-load instructions, and instructions with ms_excp=1, output ms_alu_result.
- Flush:
  - ms_valid <= 0 and nothing is accepted that cycle.
  - drop_cnt increments by the number of requests orphaned this cycle. A request is orphaned if (a) MS is pending with no buffered data and no routed data_ok this cycle, or (b) es_to_ms_valid && es_req_issued on the same cycle.
  - If data_ok for drop arrives on the same cycle as an increment, the net change is applied.
- Forwarding:
  - ms_fwd_valid = ms_valid && ms_gr_we.
  - ms_fwd_ready = ms_ready_go.
  - A load in WAIT reports not ready, so decode stalls.
- Reset mid-wait clears everything, including drop_cnt; the memory interface is reset concurrently.

Test Plan:
- ALU op, es_alu_result=0x1234, es_req_issued=0, ws_allowin=1 -> ms_to_ws_valid the cycle after accept, ms_final_result=0x1234, ms_fwd_ready=1.
- ld_b at off=3, data_ok two cycles later with rdata=0x80FF_0000 -> stays in WAIT for 2 cycles with ms_fwd_ready=0, then ms_final_result=0xFFFF_FF80. ld_bu with the same stimulus -> 0x0000_0080.
- ld_hu at off=2, rdata=0xBEEF_1234, ws_allowin=0 when data_ok fires -> buf_valid=1. Result stays 0x0000_BEEF with ms_to_ws_valid held until ws_allowin=1, then a single handshake.
- Pending ld_w plus flush, with a new ld_w issued by EX on the same flush cycle -> drop_cnt=2. The next two data_ok pulses are discarded and the third (rdata=0xCAFEF00D) goes to the following load.
- Back-to-back ld_w with data_ok each cycle and ws_allowin=1 -> one result per cycle, ms_allowin continuously 1.
- Load with es_excp=1 -> no wait, ms_excp=1, result=ms_alu_result (the bad address).

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB: waits for data-SRAM responses,
// aligns/extends load data, buffers under WB stall and discards responses of killed ops.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DROP_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [ADDR_W-1:0] es_pc,
    input  logic [4:0]        es_ld_op,
    input  logic              es_req_issued,
    input  logic [4:0]        es_dest,
    input  logic              es_gr_we,
    input  logic [ADDR_W-1:0] es_alu_result,
    input  logic              es_excp,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [ADDR_W-1:0] ms_pc,
    output logic [4:0]        ms_dest,
    output logic              ms_gr_we,
    output logic [31:0]       ms_final_result,
    output logic              ms_excp,
    output logic              ms_fwd_valid,
    output logic [4:0]        ms_fwd_dest,
    output logic              ms_fwd_ready,
    input  logic              flush
);

    logic              ms_valid;
    logic              pending;
    logic              buf_valid;
    logic [31:0]       buf_data;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_next;
    logic [4:0]        ms_ld_op;
    logic [ADDR_W-1:0] ms_alu_result;

    logic        ms_ready_go;
    logic        accept;
    logic        drop_hit;
    logic        ms_take;
    logic        orph_ms;
    logic        orph_es;
    logic [1:0]  off;
    logic [31:0] raw;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_res;

    // Responses are strictly in order: older orphaned requests answer first.
    assign drop_hit = data_sram_data_ok && (drop_cnt != '0);
    assign ms_take  = data_sram_data_ok && (drop_cnt == '0) && ms_valid && pending && !buf_valid;

    assign ms_ready_go    = !pending || buf_valid || (data_sram_data_ok && (drop_cnt == '0));
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign accept         = es_to_ms_valid && ms_allowin && !flush;

    // A flush orphans MS's outstanding request and any request EX issued this cycle.
    assign orph_ms   = flush && ms_valid && pending && !buf_valid && !ms_take;
    assign orph_es   = flush && es_to_ms_valid && es_req_issued;
    assign drop_next = drop_cnt + DROP_W'(orph_ms) + DROP_W'(orph_es) - DROP_W'(drop_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid      <= 1'b0;
            pending       <= 1'b0;
            buf_valid     <= 1'b0;
            buf_data      <= '0;
            drop_cnt      <= '0;
            ms_pc         <= '0;
            ms_ld_op      <= '0;
            ms_dest       <= '0;
            ms_gr_we      <= 1'b0;
            ms_alu_result <= '0;
            ms_excp       <= 1'b0;
        end else begin
            drop_cnt <= drop_next;
            if (flush) begin
                ms_valid  <= 1'b0;
                pending   <= 1'b0;
                buf_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid  <= es_to_ms_valid;
                buf_valid <= 1'b0;
                if (accept) begin
                    pending       <= es_req_issued && !es_excp;
                    ms_pc         <= es_pc;
                    ms_ld_op      <= es_ld_op;
                    ms_dest       <= es_dest;
                    ms_gr_we      <= es_gr_we;
                    ms_alu_result <= es_alu_result;
                    ms_excp       <= es_excp;
                end else begin
                    pending <= 1'b0;
                end
            end else if (ms_take) begin
                // WB is stalled: hold the response until it can be handed over.
                buf_valid <= 1'b1;
                buf_data  <= data_sram_rdata;
            end
        end
    end

    assign off    = ms_alu_result[1:0];
    assign raw    = buf_valid ? buf_data : data_sram_rdata;
    assign byte_v = raw[{off, 3'b000} +: 8];
    assign half_v = off[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        ld_res = raw;
        if (ms_ld_op[4])      ld_res = {{24{byte_v[7]}}, byte_v};
        else if (ms_ld_op[3]) ld_res = {{16{half_v[15]}}, half_v};
        else if (ms_ld_op[1]) ld_res = {24'd0, byte_v};
        else if (ms_ld_op[0]) ld_res = {16'd0, half_v};
    end

    assign ms_final_result = ((ms_ld_op == '0) || ms_excp) ? ms_alu_result : ld_res;

    assign ms_fwd_valid = ms_valid && ms_gr_we;
    assign ms_fwd_dest  = ms_dest;
    assign ms_fwd_ready = ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected WB results are queued at issue time and
// compared when the stage hands an instruction to WB.
module tb_mem_stage;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_W  = 5'b00100;
    localparam logic [4:0] LD_BU = 5'b00010;
    localparam logic [4:0] LD_HU = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [4:0]  es_ld_op;
    logic        es_req_issued;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic [31:0] es_alu_result;
    logic        es_excp;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic [31:0] ms_final_result;
    logic        ms_excp;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic        ms_fwd_ready;
    logic        flush;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_ld_op(es_ld_op), .es_req_issued(es_req_issued),
        .es_dest(es_dest), .es_gr_we(es_gr_we), .es_alu_result(es_alu_result),
        .es_excp(es_excp),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_final_result(ms_final_result), .ms_excp(ms_excp),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
        .ms_fwd_ready(ms_fwd_ready), .flush(flush)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic        excp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   outstanding = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] res, input logic excp);
        exp_t e;
        e.pc = pc; e.res = res; e.excp = excp;
        sb.push_back(e);
    endtask

    // Sample point: protocol check on responses, then scoreboard on WB handshake.
    task automatic at_neg();
        exp_t e;
        @(negedge clk);
        if (data_sram_data_ok) chk("data_ok_has_consumer", 32'(outstanding > 0), 32'd1);
        if (ms_to_ws_valid === 1'b1 && ws_allowin) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_handshake: observed pc %h expected no result", ms_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", ms_pc, e.pc);
                chk("sb_result", ms_final_result, e.res);
                chk("sb_excp", 32'(ms_excp), 32'(e.excp));
            end
        end
    endtask

    task automatic at_pos();
        int inc, dec;
        inc = (es_to_ms_valid && es_req_issued) ? 1 : 0;
        dec = data_sram_data_ok ? 1 : 0;
        @(posedge clk);
        outstanding += inc - dec;
        #1;
    endtask

    task automatic cyc();
        at_neg();
        at_pos();
    endtask

    task automatic drive_es(input logic [31:0] pc, input logic [4:0] op, input logic req,
                            input logic [31:0] alu, input logic excp);
        es_to_ms_valid = 1'b1;
        es_pc = pc; es_ld_op = op; es_req_issued = req;
        es_dest = pc[6:2]; es_gr_we = 1'b1; es_alu_result = alu; es_excp = excp;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] op, input logic req,
                        input logic [31:0] alu, input logic excp);
        drive_es(pc, op, req, alu, excp);
        at_neg();
        chk("allowin_on_send", 32'(ms_allowin), 32'd1);
        at_pos();
        es_to_ms_valid = 1'b0;
    endtask

    // Load whose response arrives two cycles after the accept cycle's follower.
    task automatic load_wait(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] alu,
                             input logic [31:0] rdata, input logic [31:0] exp);
        push(pc, exp, 1'b0);
        send(pc, op, 1'b1, alu, 1'b0);
        repeat (2) begin
            at_neg();
            chk("wait_fwd_ready", 32'(ms_fwd_ready), 32'd0);
            chk("wait_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
            chk("wait_fwd_valid", 32'(ms_fwd_valid), 32'd1);
            at_pos();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
        at_neg();
        chk("resp_to_ws_valid", 32'(ms_to_ws_valid), 32'd1);
        at_pos();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1;
        es_to_ms_valid = 1'b0; es_pc = '0; es_ld_op = '0; es_req_issued = 1'b0;
        es_dest = '0; es_gr_we = 1'b0; es_alu_result = '0; es_excp = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        at_pos(); at_pos();
        reset = 1'b0;

        at_neg();
        chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_fwd_valid", 32'(ms_fwd_valid), 32'd0);
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_pc", ms_pc, 32'd0);
        chk("rst_result", ms_final_result, 32'd0);
        chk("rst_excp", 32'(ms_excp), 32'd0);
        at_pos();

        // ALU op: no request, result available the cycle after accept
        push(32'h100, 32'h1234, 1'b0);
        send(32'h100, 5'd0, 1'b0, 32'h1234, 1'b0);
        at_neg();
        chk("alu_to_ws_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("alu_fwd_ready", 32'(ms_fwd_ready), 32'd1);
        chk("alu_fwd_valid", 32'(ms_fwd_valid), 32'd1);
        chk("alu_fwd_dest", 32'(ms_fwd_dest), 32'd0);
        at_pos();

        load_wait(32'h200, LD_B,  32'h1003, 32'h80FF_0000, 32'hFFFF_FF80);
        load_wait(32'h210, LD_BU, 32'h1003, 32'h80FF_0000, 32'h0000_0080);

        // ld_hu with WB stalled on the response cycle: data must come from the buffer
        push(32'h300, 32'h0000_BEEF, 1'b0);
        send(32'h300, LD_HU, 1'b1, 32'h2002, 1'b0);
        ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_1234;
        at_neg();
        chk("hu_valid_on_ok", 32'(ms_to_ws_valid), 32'd1);
        chk("hu_result_on_ok", ms_final_result, 32'h0000_BEEF);
        at_pos();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        repeat (2) begin
            at_neg();
            chk("hu_hold_valid", 32'(ms_to_ws_valid), 32'd1);
            chk("hu_hold_result", ms_final_result, 32'h0000_BEEF);
            chk("hu_hold_allowin", 32'(ms_allowin), 32'd0);
            chk("hu_hold_ready", 32'(ms_fwd_ready), 32'd1);
            at_pos();
        end
        ws_allowin = 1'b1;
        cyc();
        at_neg();
        chk("hu_single_handshake", 32'(ms_to_ws_valid), 32'd0);
        at_pos();

        // Flush with pending ld_w plus a new ld_w issued the same cycle: two orphans
        send(32'h400, LD_W, 1'b1, 32'h400, 1'b0);
        drive_es(32'h404, LD_W, 1'b1, 32'h404, 1'b0);
        flush = 1'b1;
        at_neg();
        chk("flush_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        at_pos();
        flush = 1'b0; es_to_ms_valid = 1'b0;
        at_neg();
        chk("flush_killed", 32'(ms_fwd_valid), 32'd0);
        chk("flush_allowin", 32'(ms_allowin), 32'd1);
        at_pos();
        push(32'h408, 32'hCAFE_F00D, 1'b0);
        send(32'h408, LD_W, 1'b1, 32'h408, 1'b0);
        data_sram_data_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_sram_rdata = (i == 0) ? 32'h1111_1111 : 32'h2222_2222;
            at_neg();
            chk("drop_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
            chk("drop_fwd_ready", 32'(ms_fwd_ready), 32'd0);
            at_pos();
        end
        data_sram_rdata = 32'hCAFE_F00D;
        at_neg();
        chk("after_drop_valid", 32'(ms_to_ws_valid), 32'd1);
        at_pos();
        data_sram_data_ok = 1'b0;

        // Back-to-back ld_w, each response the cycle after its accept
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                push(32'h500 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
                drive_es(32'h500 + 32'(4 * i), LD_W, 1'b1, 32'h500 + 32'(4 * i), 1'b0);
            end else begin
                es_to_ms_valid = 1'b0;
            end
            data_sram_data_ok = (i > 0);
            data_sram_rdata = 32'hA000_0000 + 32'(i - 1);
            at_neg();
            chk("b2b_allowin", 32'(ms_allowin), 32'd1);
            at_pos();
        end
        data_sram_data_ok = 1'b0;

        // Faulting load: no wait, bad address passed through
        push(32'h600, 32'h601, 1'b1);
        send(32'h600, LD_W, 1'b0, 32'h601, 1'b1);
        at_neg();
        chk("excp_to_ws_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("excp_flag", 32'(ms_excp), 32'd1);
        chk("excp_fwd_ready", 32'(ms_fwd_ready), 32'd1);
        at_pos();

        // ld_h sign extension, response right after accept
        push(32'h700, 32'hFFFF_8001, 1'b0);
        send(32'h700, LD_H, 1'b1, 32'h700, 1'b0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_8001;
        cyc();
        data_sram_data_ok = 1'b0;

        // Orphan a request, then reset: discard counter must be cleared
        send(32'h800, LD_W, 1'b1, 32'h800, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        reset = 1'b1;
        at_pos();
        reset = 1'b0;
        outstanding = 0;
        at_neg();
        chk("rst_mid_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_mid_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_mid_fwd_valid", 32'(ms_fwd_valid), 32'd0);
        at_pos();
        push(32'h900, 32'h55AA_55AA, 1'b0);
        send(32'h900, LD_W, 1'b1, 32'h900, 1'b0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55AA_55AA;
        at_neg();
        chk("rst_drop_cleared", 32'(ms_to_ws_valid), 32'd1);
        at_pos();
        data_sram_data_ok = 1'b0;

        cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
